// File: rtl/dma_utils_pkg.sv
// ---------------------------------------------------------------------------
// dma_utils_pkg
// Shared types for the DMA descriptor scheduler slice.
//   dma_sched_st_t : scheduler FSM state encoding (IDLE/SELECT/WAIT/DONE)
//   desc_idx_t     : generic descriptor index, wide enough for any slot
//                    count this block is ever built with; consumers slice it
//                    down to their own IDX_W.
// ---------------------------------------------------------------------------
package dma_utils_pkg;

    localparam int DMA_IDX_MAX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } dma_sched_st_t;

    typedef logic [DMA_IDX_MAX_W-1:0] desc_idx_t;

endpackage

// File: rtl/dma_desc_pick.sv
// ---------------------------------------------------------------------------
// dma_desc_pick
// Purely combinational search for the lowest enabled descriptor whose index
// is at or above the scheduler cursor.
// Ports:
//   i_desc_en [NUM_DESC] : per-descriptor enable bits
//   i_cursor  [IDX_W+1]  : first index that may be chosen (may equal NUM_DESC)
//   o_found              : an eligible descriptor exists
//   o_idx     [IDX_W]    : index of that descriptor (0 when none found)
// ---------------------------------------------------------------------------
module dma_desc_pick
    import dma_utils_pkg::*;
#(
    parameter int NUM_DESC = 2,
    parameter int IDX_W    = $clog2(NUM_DESC)
)(
    input  logic [NUM_DESC-1:0] i_desc_en,
    input  logic [IDX_W:0]      i_cursor,
    output logic                o_found,
    output logic [IDX_W-1:0]    o_idx
);

    // Walk from the top slot downwards so the last hit written is the
    // lowest eligible index; the cursor is one bit wider than an index so
    // "past the last slot" never aliases back onto slot 0.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NUM_DESC - 1; k >= 0; k--) begin
            if (i_desc_en[k] && ((IDX_W+1)'(k) >= i_cursor)) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/dma_desc_scheduler.sv
// ---------------------------------------------------------------------------
// dma_desc_scheduler
// Walks the enabled descriptor slots in ascending order, launching each one
// on the read and write streamers together and waiting for both to finish
// before moving to the next. Tracks abort and AXI error status for the CSRs.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   dma_go_i / dma_abort_i        : CSR start pulse / abort level
//   desc_en_i [NUM_DESC]          : per-descriptor enable
//   rd_str_valid_o, rd_str_idx_o  : read-streamer launch strobe + index
//   rd_done_i                     : read streamer finished current descriptor
//   wr_str_valid_o, wr_str_idx_o  : write-streamer launch strobe + index
//   wr_done_i                     : write streamer finished current descriptor
//   str_abort_o                   : abort to both streamers
//   axi_err_i                     : one-cycle AXI SLVERR/DECERR pulse
//   dma_active_o, dma_done_o      : busy level / one-cycle completion pulse
//   dma_error_o, err_idx_o        : sticky error flag / index of first error
// Build option:
//   DMA_ERR_ABORT_EN : when defined, the first AXI error also raises a
//                      registered abort that stops the run after the current
//                      descriptor drains.
// ---------------------------------------------------------------------------
module dma_desc_scheduler
    import dma_utils_pkg::*;
#(
    parameter int NUM_DESC = 2,
    parameter int IDX_W    = $clog2(NUM_DESC)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                dma_go_i,
    input  logic                dma_abort_i,
    input  logic [NUM_DESC-1:0] desc_en_i,
    output logic                rd_str_valid_o,
    output logic [IDX_W-1:0]    rd_str_idx_o,
    input  logic                rd_done_i,
    output logic                wr_str_valid_o,
    output logic [IDX_W-1:0]    wr_str_idx_o,
    input  logic                wr_done_i,
    output logic                str_abort_o,
    input  logic                axi_err_i,
    output logic                dma_active_o,
    output logic                dma_done_o,
    output logic                dma_error_o,
    output logic [IDX_W-1:0]    err_idx_o
);

    dma_sched_st_t    r_state;
    dma_sched_st_t    w_next_state;
    logic [IDX_W:0]   r_cursor;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_err_idx;
    logic             r_rd_done;
    logic             r_wr_done;
    logic             r_aborted;
    logic             r_error;

    logic             w_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_rd_seen;
    logic             w_wr_seen;
    logic             w_both_done;
    logic [IDX_W:0]   w_next_cursor;
    logic             w_last_desc;
    logic             w_active;
    logic             w_launch;
    logic [IDX_W-1:0] w_cur_idx;
    logic             w_err_abort;
    logic             w_str_abort;

    dma_desc_pick #(
        .NUM_DESC (NUM_DESC),
        .IDX_W    (IDX_W)
    ) u_pick (
        .i_desc_en (desc_en_i),
        .i_cursor  (r_cursor),
        .o_found   (w_found),
        .o_idx     (w_pick_idx)
    );

    // A done pulse counts whether it arrived earlier (sticky flag) or in
    // this very cycle, so the two streamers may finish in any order or
    // together.
    assign w_rd_seen     = r_rd_done | rd_done_i;
    assign w_wr_seen     = r_wr_done | wr_done_i;
    assign w_both_done   = w_rd_seen & w_wr_seen;
    assign w_next_cursor = (IDX_W+1)'(r_idx) + (IDX_W+1)'(1);
    assign w_last_desc   = (w_next_cursor == (IDX_W+1)'(NUM_DESC));
    assign w_active      = (r_state == ST_SELECT) || (r_state == ST_WAIT);
    assign w_launch      = (r_state == ST_SELECT) && !w_str_abort && w_found;
    assign w_cur_idx     = w_launch ? w_pick_idx : r_idx;
    assign w_str_abort   = dma_abort_i | w_err_abort;
    assign str_abort_o   = w_str_abort;

`ifdef DMA_ERR_ABORT_EN
    logic r_err_abort;

    // The error-abort holds from the cycle after the first error through
    // the DONE cycle, so the streamers drain and no further slot launches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_abort <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_err_abort <= 1'b0;
        end else if (w_active && axi_err_i) begin
            r_err_abort <= 1'b1;
        end
    end

    assign w_err_abort = r_err_abort;
`else
    assign w_err_abort = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Abort beats go in IDLE, and an abort seen in
    // SELECT ends the run without launching. In WAIT the run ends once both
    // streamers report done and either the last slot was handled or an
    // abort was seen at any point during this descriptor.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dma_go_i && !dma_abort_i) begin
                    w_next_state = ST_SELECT;
                end
            end
            ST_SELECT: begin
                w_next_state = w_launch ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if (w_both_done) begin
                    w_next_state = (w_last_desc || r_aborted || w_str_abort)
                                   ? ST_DONE : ST_SELECT;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs. Launch strobes exist only in the SELECT cycle that found a
    // slot; between launches the index outputs hold the last launched slot.
    always_comb begin
        rd_str_valid_o = w_launch;
        wr_str_valid_o = w_launch;
        rd_str_idx_o   = w_cur_idx;
        wr_str_idx_o   = w_cur_idx;
        dma_active_o   = w_active;
        dma_done_o     = (r_state == ST_DONE);
        dma_error_o    = r_error;
        err_idx_o      = r_err_idx;
    end

    // Datapath registers: cursor, current index, sticky done flags, abort
    // history and error status. A start clears the status from the previous
    // run; only the first error of a run records its descriptor index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cursor  <= '0;
            r_idx     <= '0;
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
            r_aborted <= 1'b0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dma_go_i && !dma_abort_i) begin
                        r_cursor  <= '0;
                        r_aborted <= 1'b0;
                        r_error   <= 1'b0;
                        r_rd_done <= 1'b0;
                        r_wr_done <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    if (w_launch) begin
                        r_idx <= w_pick_idx;
                    end
                end
                ST_WAIT: begin
                    if (w_str_abort) begin
                        r_aborted <= 1'b1;
                    end
                    if (w_both_done) begin
                        r_rd_done <= 1'b0;
                        r_wr_done <= 1'b0;
                        r_cursor  <= w_next_cursor;
                    end else begin
                        r_rd_done <= w_rd_seen;
                        r_wr_done <= w_wr_seen;
                    end
                end
                default: begin
                end
            endcase
            if (w_active && axi_err_i) begin
                r_error <= 1'b1;
                if (!r_error) begin
                    r_err_idx <= w_cur_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dma_desc_scheduler
// Scoreboard bench for dma_desc_scheduler (NUM_DESC = 2). Each scenario
// pushes the descriptor indices it expects to see launched; a negedge
// monitor pops and compares them as launches appear, and each scenario
// checks timing, done pulses and status inline.
// ---------------------------------------------------------------------------
module tb_dma_desc_scheduler;
    import dma_utils_pkg::*;

    localparam int NUM_DESC = 2;
    localparam int IDX_W    = 1;

`ifdef DMA_ERR_ABORT_EN
    localparam bit ERR_ABORT = 1'b1;
`else
    localparam bit ERR_ABORT = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                dmaGo;
    logic                dmaAbort;
    logic [NUM_DESC-1:0] descEn;
    logic                rdValid;
    logic [IDX_W-1:0]    rdIdx;
    logic                rdDone;
    logic                wrValid;
    logic [IDX_W-1:0]    wrIdx;
    logic                wrDone;
    logic                strAbort;
    logic                axiErr;
    logic                active;
    logic                dmaDone;
    logic                dmaError;
    logic [IDX_W-1:0]    errIdx;
    logic [3*IDX_W+5:0]  outVec;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int launchCount = 0;
    int lastLaunchCycle = -1;
    int lastLaunchIdx = -1;
    int doneCount = 0;
    int lastDoneCycle = -1;
    desc_idx_t expQ[$];

    dma_desc_scheduler #(
        .NUM_DESC (NUM_DESC),
        .IDX_W    (IDX_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dma_go_i       (dmaGo),
        .dma_abort_i    (dmaAbort),
        .desc_en_i      (descEn),
        .rd_str_valid_o (rdValid),
        .rd_str_idx_o   (rdIdx),
        .rd_done_i      (rdDone),
        .wr_str_valid_o (wrValid),
        .wr_str_idx_o   (wrIdx),
        .wr_done_i      (wrDone),
        .str_abort_o    (strAbort),
        .axi_err_i      (axiErr),
        .dma_active_o   (active),
        .dma_done_o     (dmaDone),
        .dma_error_o    (dmaError),
        .err_idx_o      (errIdx)
    );

    assign outVec = {rdValid, rdIdx, wrValid, wrIdx, strAbort, active,
                     dmaDone, dmaError, errIdx};

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Cycle counter; cycle k spans from posedge k to posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    // Launch/done monitor: sampled mid-cycle, pops the expected launch index
    // from the scoreboard and records when launches and done pulses happen.
    always @(negedge clk) begin
        if (rdValid === 1'b1 || wrValid === 1'b1) begin
            desc_idx_t expIdx;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL launch_unexpected: rd %0b/%0d wr %0b/%0d at cycle %0d, expected no launch",
                         rdValid, rdIdx, wrValid, wrIdx, cyc);
            end else begin
                expIdx = expQ.pop_front();
                if (rdValid !== 1'b1 || wrValid !== 1'b1 ||
                    rdIdx !== expIdx[IDX_W-1:0] || wrIdx !== expIdx[IDX_W-1:0]) begin
                    errors++;
                    $display("[TB] FAIL launch_idx: rd %0b/%0d wr %0b/%0d at cycle %0d, expected both valid with idx %0d",
                             rdValid, rdIdx, wrValid, wrIdx, cyc, expIdx);
                end
            end
            launchCount++;
            lastLaunchCycle = cyc;
            lastLaunchIdx   = int'(rdIdx);
        end
        if (dmaDone === 1'b1) begin
            doneCount++;
            lastDoneCycle = cyc;
        end
    end

    // Hard stop if the bench itself ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleNow();
        @(negedge clk);
        #1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) nextCycle();
    endtask

    task automatic startRun(input logic [NUM_DESC-1:0] en, output int t);
        nextCycle();
        descEn = en;
        dmaGo  = 1'b1;
        nextCycle();
        dmaGo  = 1'b0;
        t = cyc;
    endtask

    task automatic pulseDones();
        rdDone = 1'b1;
        wrDone = 1'b1;
        nextCycle();
        rdDone = 1'b0;
        wrDone = 1'b0;
    endtask

    task automatic waitForDone(input int baseDone, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sampleNow();
            if (doneCount != baseDone) begin
                seen = 1'b1;
                break;
            end
            nextCycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dmaGo = 1'b0; dmaAbort = 1'b0; descEn = '0;
        rdDone = 1'b0; wrDone = 1'b0; axiErr = 1'b0;
        repeat (2) nextCycle();
        sampleNow();
        checks++;
        if (outVec !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, expected all zero", outVec);
        end
        nextCycle();
        rst = 1'b0;
        sampleNow();
        checks++;
        if (outVec !== '0) begin
            errors++;
            $display("[TB] FAIL post_reset_outputs: got %b, expected all zero", outVec);
        end
    endtask

    task automatic test_two_desc();
        int t, base, bd;
        bit seen;
        base = launchCount; bd = doneCount;
        expQ.push_back(desc_idx_t'(0));
        expQ.push_back(desc_idx_t'(1));
        startRun(2'b11, t);
        sampleNow();
        checks++;
        if (launchCount !== base + 1 || lastLaunchCycle !== t) begin
            errors++;
            $display("[TB] FAIL first_launch: count %0d cycle %0d, expected %0d at %0d",
                     launchCount - base, lastLaunchCycle, 1, t);
        end
        waitUntil(t + 2);
        sampleNow();
        checks++;
        if (active !== 1'b1 || dmaDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_active: active %0b done %0b, expected 1 0", active, dmaDone);
        end
        waitUntil(t + 3);
        rdDone = 1'b1;
        nextCycle();
        rdDone = 1'b0;
        waitUntil(t + 5);
        wrDone = 1'b1;
        nextCycle();
        wrDone = 1'b0;
        sampleNow();
        checks++;
        if (launchCount !== base + 2 || lastLaunchCycle !== t + 6) begin
            errors++;
            $display("[TB] FAIL second_launch_timing: count %0d cycle %0d, expected 2 at %0d",
                     launchCount - base, lastLaunchCycle, t + 6);
        end
        waitUntil(t + 8);
        pulseDones();
        waitForDone(bd, 10, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL done_after_two: no dma_done within budget, expected a pulse");
        end
        repeat (3) nextCycle();
        sampleNow();
        checks++;
        if (doneCount !== bd + 1 || active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_single_pulse: pulses %0d active %0b, expected 1 0",
                     doneCount - bd, active);
        end
    endtask

    task automatic test_sparse();
        int t, g, base, bd;
        bit seen;
        base = launchCount; bd = doneCount;
        expQ.push_back(desc_idx_t'(1));
        startRun(2'b10, t);
        sampleNow();
        checks++;
        if (launchCount !== base + 1 || lastLaunchIdx !== 1) begin
            errors++;
            $display("[TB] FAIL sparse_launch_idx: count %0d idx %0d, expected 1 1",
                     launchCount - base, lastLaunchIdx);
        end
        waitUntil(t + 2);
        pulseDones();
        waitForDone(bd, 10, seen);
        checks++;
        if (!seen || launchCount !== base + 1) begin
            errors++;
            $display("[TB] FAIL sparse_done: done %0b launches %0d, expected 1 1",
                     seen, launchCount - base);
        end
        base = launchCount;
        repeat (2) nextCycle();
        startRun(2'b00, t);
        g = t - 1;
        waitUntil(g + 2);
        sampleNow();
        checks++;
        if (dmaDone !== 1'b1 || lastDoneCycle !== g + 2) begin
            errors++;
            $display("[TB] FAIL empty_done_timing: done %0b last cycle %0d, expected 1 at %0d",
                     dmaDone, lastDoneCycle, g + 2);
        end
        checks++;
        if (launchCount !== base) begin
            errors++;
            $display("[TB] FAIL empty_no_launch: launches %0d, expected 0", launchCount - base);
        end
    endtask

    task automatic test_back_to_back();
        int t, base, bd;
        bit seen;
        base = launchCount; bd = doneCount;
        expQ.push_back(desc_idx_t'(0));
        expQ.push_back(desc_idx_t'(1));
        startRun(2'b11, t);
        waitUntil(t + 1);
        dmaGo = 1'b1;
        nextCycle();
        dmaGo = 1'b0;
        sampleNow();
        checks++;
        if (launchCount !== base + 1) begin
            errors++;
            $display("[TB] FAIL go_ignored_in_wait: launches %0d, expected 1", launchCount - base);
        end
        waitUntil(t + 3);
        pulseDones();
        sampleNow();
        checks++;
        if (lastLaunchCycle !== t + 4 || lastLaunchIdx !== 1) begin
            errors++;
            $display("[TB] FAIL same_cycle_done_accept: launch idx %0d at %0d, expected 1 at %0d",
                     lastLaunchIdx, lastLaunchCycle, t + 4);
        end
        waitUntil(t + 6);
        pulseDones();
        waitForDone(bd, 10, seen);
        checks++;
        if (!seen || launchCount !== base + 2) begin
            errors++;
            $display("[TB] FAIL back_to_back_done: done %0b launches %0d, expected 1 2",
                     seen, launchCount - base);
        end
    endtask

    task automatic test_abort();
        int t, base, bd;
        bit seen;
        base = launchCount; bd = doneCount;
        expQ.push_back(desc_idx_t'(0));
        startRun(2'b11, t);
        waitUntil(t + 1);
        dmaAbort = 1'b1;
        sampleNow();
        checks++;
        if (strAbort !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_passthrough: str_abort %0b, expected 1", strAbort);
        end
        nextCycle();
        pulseDones();
        waitForDone(bd, 10, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL abort_done: no dma_done within budget, expected a pulse");
        end
        checks++;
        if (launchCount !== base + 1) begin
            errors++;
            $display("[TB] FAIL abort_no_second_launch: launches %0d, expected 1", launchCount - base);
        end
        nextCycle();
        dmaAbort = 1'b0;
        repeat (3) nextCycle();
        sampleNow();
        checks++;
        if (doneCount !== bd + 1) begin
            errors++;
            $display("[TB] FAIL abort_single_done: pulses %0d, expected 1", doneCount - bd);
        end
    endtask

    task automatic test_error();
        int t, base, bd;
        bit seen;
        base = launchCount; bd = doneCount;
        expQ.push_back(desc_idx_t'(0));
        expQ.push_back(desc_idx_t'(1));
        startRun(2'b11, t);
        waitUntil(t + 1);
        pulseDones();
        waitUntil(t + 3);
        axiErr = 1'b1;
        sampleNow();
        checks++;
        if (dmaError !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_not_early: error %0b, expected 0", dmaError);
        end
        nextCycle();
        axiErr = 1'b0;
        sampleNow();
        checks++;
        if (dmaError !== 1'b1 || errIdx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL error_capture: error %0b idx %0d, expected 1 1", dmaError, errIdx);
        end
        checks++;
        if (strAbort !== ERR_ABORT) begin
            errors++;
            $display("[TB] FAIL error_abort: str_abort %0b, expected %0b", strAbort, ERR_ABORT);
        end
        nextCycle();
        pulseDones();
        waitForDone(bd, 10, seen);
        checks++;
        if (!seen || dmaError !== 1'b1 || launchCount !== base + 2) begin
            errors++;
            $display("[TB] FAIL error_sticky_after_done: done %0b error %0b launches %0d, expected 1 1 2",
                     seen, dmaError, launchCount - base);
        end
        bd = doneCount;
        repeat (2) nextCycle();
        startRun(2'b00, t);
        sampleNow();
        checks++;
        if (dmaError !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_cleared_by_go: error %0b, expected 0", dmaError);
        end
        waitForDone(bd, 10, seen);
    endtask

    task automatic test_reset_mid();
        int t, base, bd;
        bit seen;
        base = launchCount; bd = doneCount;
        expQ.push_back(desc_idx_t'(0));
        startRun(2'b11, t);
        waitUntil(t + 1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        sampleNow();
        checks++;
        if (outVec !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %b, expected all zero", outVec);
        end
        repeat (5) nextCycle();
        sampleNow();
        checks++;
        if (doneCount !== bd || launchCount !== base + 1) begin
            errors++;
            $display("[TB] FAIL reset_no_done: pulses %0d launches %0d, expected 0 1",
                     doneCount - bd, launchCount - base);
        end
        expQ.push_back(desc_idx_t'(0));
        expQ.push_back(desc_idx_t'(1));
        startRun(2'b11, t);
        sampleNow();
        checks++;
        if (lastLaunchIdx !== 0 || lastLaunchCycle !== t) begin
            errors++;
            $display("[TB] FAIL restart_idx0: idx %0d at %0d, expected 0 at %0d",
                     lastLaunchIdx, lastLaunchCycle, t);
        end
        waitUntil(t + 1);
        pulseDones();
        waitUntil(t + 4);
        pulseDones();
        waitForDone(bd, 10, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL restart_done: no dma_done within budget, expected a pulse");
        end
    endtask

    // Scenario sequence followed by the scoreboard drain check and summary.
    initial begin
        test_reset();
        test_two_desc();
        test_sparse();
        test_back_to_back();
        test_abort();
        test_error();
        test_reset_mid();
        repeat (3) nextCycle();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drained: %0d launches outstanding, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
